// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage with a single-outstanding-request
// memory interface and the IF/ID pipeline register.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   PCNext, PCSrcE, stallF branch-unit next PC, EX redirect, hazard stall
//   imem_req, imem_addr    request strobe and address (always PCF)
//   imem_gnt               request accepted this cycle
//   imem_rvalid, imem_rdata response strobe and instruction word
//   PCF                    current fetch PC
//   InstrD, PCD, PCPlus4D, validD   IF/ID register
//
// state | meaning
// FETCH | idle, issue a request for PCF when not stalled/redirected
// WAIT  | request granted, waiting for its response
// HOLD  | response arrived during a stall, word parked in hold register
// DRAIN | redirect hit an outstanding request, swallow its response

package rv32i_pkg;
  parameter int DPW = 32;
endpackage

module fetch_unit #(
  parameter int             DPW       = rv32i_pkg::DPW,
  parameter logic [DPW-1:0] RESET_PC  = '0,
  parameter logic [31:0]    NOP_INSTR = 32'h0000_0013
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DPW-1:0] PCNext,
  input  logic           PCSrcE,
  input  logic           stallF,
  output logic           imem_req,
  output logic [DPW-1:0] imem_addr,
  input  logic           imem_gnt,
  input  logic           imem_rvalid,
  input  logic [31:0]    imem_rdata,
  output logic [DPW-1:0] PCF,
  output logic [31:0]    InstrD,
  output logic [DPW-1:0] PCD,
  output logic [DPW-1:0] PCPlus4D,
  output logic           validD
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [DPW-1:0] pcf_q, pcf_d;
  logic [31:0]    instr_q, instr_d;
  logic [DPW-1:0] pcd_q, pcd_d;
  logic [DPW-1:0] pc4_q, pc4_d;
  logic           valid_q, valid_d;
  logic [31:0]    hold_q, hold_d;

  logic           accept;
  logic [31:0]    word;
  logic [DPW-1:0] pc_load;

  // Loads always force word alignment, so the two LSBs are never consumed.
  logic unused_pcnext_lsbs;
  assign unused_pcnext_lsbs = ^PCNext[1:0];

  assign pc_load = {PCNext[DPW-1:2], 2'b00};

  always_comb begin
    state_d  = state_q;
    pcf_d    = pcf_q;
    instr_d  = instr_q;
    pcd_d    = pcd_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    hold_d   = hold_q;
    accept   = 1'b0;
    word     = imem_rdata;
    imem_req = (state_q == ST_FETCH) & ~PCSrcE & ~stallF & ~rst;

    case (state_q)
      ST_FETCH: begin
        if (imem_req && imem_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (PCSrcE) begin
          state_d = imem_rvalid ? ST_FETCH : ST_DRAIN;
        end else if (imem_rvalid) begin
          if (stallF) begin
            hold_d  = imem_rdata;
            state_d = ST_HOLD;
          end else begin
            accept  = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HOLD: begin
        if (PCSrcE) begin
          state_d = ST_FETCH;
        end else if (!stallF) begin
          accept  = 1'b1;
          word    = hold_q;
          state_d = ST_FETCH;
        end
      end
      default: begin
        if (imem_rvalid) state_d = ST_FETCH;
      end
    endcase

    // rst > PCSrcE > stallF > accept > bubble
    if (PCSrcE) begin
      pcf_d   = pc_load;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!stallF) begin
      if (accept) begin
        instr_d = word;
        pcd_d   = pcf_q;
        pc4_d   = pcf_q + DPW'(4);
        valid_d = 1'b1;
        pcf_d   = pc_load;
      end else if (state_q != ST_DRAIN) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pcf_q   <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcd_q   <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end

  assign imem_addr = pcf_q;
  assign PCF       = pcf_q;
  assign InstrD    = instr_q;
  assign PCD       = pcd_q;
  assign PCPlus4D  = pc4_q;
  assign validD    = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios with literal expectations, followed by a
// randomized run against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] pcnext;
  logic        pcsrc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] PCF;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        validD;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .PCNext     (pcnext),
    .PCSrcE     (pcsrc),
    .stallF     (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (gnt),
    .imem_rvalid(rvalid),
    .imem_rdata (rdata),
    .PCF        (PCF),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .validD     (validD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: request bookkeeping as flags, plus the architectural IF/ID values.
  logic        model_ok = 1'b0;
  logic        m_wait, m_drain, m_held;
  logic [31:0] m_hword, m_pc, m_instr, m_pcd, m_pc4;
  logic        m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic        idle, req, resp;
    logic [31:0] w;
    if (rst) begin
      m_pc = 32'h0; m_instr = NOP; m_pcd = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_wait = 1'b0; m_drain = 1'b0; m_held = 1'b0; m_hword = 32'h0;
      model_ok = 1'b1;
      return;
    end
    if (!model_ok) return;
    idle = !(m_wait || m_drain || m_held);
    req  = idle && !pcsrc && !stall;
    resp = rvalid && (m_wait || m_drain);
    if (pcsrc) begin
      m_pc = {pcnext[31:2], 2'b00};
      m_instr = NOP;
      m_valid = 1'b0;
      m_held = 1'b0;
      if (m_wait || m_drain) begin
        m_drain = !resp;
        m_wait = 1'b0;
      end
    end else if (stall) begin
      if (m_wait && resp) begin
        m_held = 1'b1;
        m_hword = rdata;
        m_wait = 1'b0;
      end
      if (m_drain && resp) m_drain = 1'b0;
    end else if (m_drain) begin
      if (resp) m_drain = 1'b0;
    end else if ((m_wait && resp) || m_held) begin
      w = m_held ? m_hword : rdata;
      m_instr = w;
      m_pcd = m_pc;
      m_pc4 = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc = {pcnext[31:2], 2'b00};
      m_wait = 1'b0;
      m_held = 1'b0;
    end else begin
      m_instr = NOP;
      m_valid = 1'b0;
    end
    if (req && gnt) m_wait = 1'b1;
  endtask

  task automatic compare_all();
    logic exp_req;
    if (!model_ok) return;
    exp_req = !rst && !(m_wait || m_drain || m_held) && !pcsrc && !stall;
    chk("PCF", PCF, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("InstrD", InstrD, m_instr);
    chk("PCD", PCD, m_pcd);
    chk("PCPlus4D", PCPlus4D, m_pc4);
    chk("validD", {31'b0, validD}, {31'b0, m_valid});
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
  endtask

  // One clock: compare on the falling edge, advance the model on the rising
  // edge, and return 2 time units later so the caller can drive new inputs.
  task automatic cyc();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic idle_in();
    rst = 1'b0; pcsrc = 1'b0; stall = 1'b0; gnt = 1'b0; rvalid = 1'b0;
  endtask

  initial begin
    int          mem_cnt;
    logic        hs;
    logic [31:0] r;

    idle_in();
    rst = 1'b1;
    pcnext = 32'h0;
    rdata = 32'h0;
    cyc();

    // reset then fetch
    idle_in(); pcnext = 32'h4; gnt = 1'b1;
    #1;
    chk("rst_PCF", PCF, 32'h0);
    chk("rst_validD", {31'b0, validD}, 32'h0);
    chk("rst_InstrD", InstrD, NOP);
    chk("rst_PCD", PCD, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h1);
    cyc();
    idle_in(); rvalid = 1'b1; rdata = 32'h0050_0093;
    cyc();
    idle_in();
    #1;
    chk("t1_InstrD", InstrD, 32'h0050_0093);
    chk("t1_PCD", PCD, 32'h0);
    chk("t1_PCPlus4D", PCPlus4D, 32'h4);
    chk("t1_validD", {31'b0, validD}, 32'h1);
    chk("t1_PCF", PCF, 32'h4);

    // redirect while a response is pending
    gnt = 1'b1; pcnext = 32'h8;
    cyc();
    idle_in(); pcsrc = 1'b1; pcnext = 32'h100;
    cyc();
    idle_in(); rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
    #1;
    chk("t2_PCF", PCF, 32'h100);
    chk("t2_validD", {31'b0, validD}, 32'h0);
    chk("t2_drain_noreq", {31'b0, imem_req}, 32'h0);
    cyc();
    idle_in();
    #1;
    chk("t2_InstrD", InstrD, NOP);
    chk("t2_addr", imem_addr, 32'h100);
    chk("t2_req", {31'b0, imem_req}, 32'h1);

    // stall on response
    gnt = 1'b1;
    cyc();
    idle_in(); rvalid = 1'b1; rdata = 32'hDEAD_BEEF; stall = 1'b1;
    cyc();
    for (int k = 0; k < 3; k++) begin
      idle_in(); stall = 1'b1;
      #1;
      chk("t3_hold_InstrD", InstrD, NOP);
      chk("t3_hold_validD", {31'b0, validD}, 32'h0);
      chk("t3_hold_PCF", PCF, 32'h100);
      chk("t3_hold_req", {31'b0, imem_req}, 32'h0);
      cyc();
    end
    idle_in(); pcnext = 32'h104;
    cyc();
    idle_in();
    #1;
    chk("t3_InstrD", InstrD, 32'hDEAD_BEEF);
    chk("t3_validD", {31'b0, validD}, 32'h1);
    chk("t3_PCD", PCD, 32'h100);
    chk("t3_PCPlus4D", PCPlus4D, 32'h104);
    chk("t3_PCF", PCF, 32'h104);

    // redirect, stall and response together
    gnt = 1'b1;
    cyc();
    idle_in(); pcsrc = 1'b1; stall = 1'b1; rvalid = 1'b1; rdata = 32'h1234_5678; pcnext = 32'h200;
    cyc();
    idle_in();
    #1;
    chk("t4_PCF", PCF, 32'h200);
    chk("t4_validD", {31'b0, validD}, 32'h0);
    chk("t4_InstrD", InstrD, NOP);
    chk("t4_req", {31'b0, imem_req}, 32'h1);

    // alignment and wrap
    pcsrc = 1'b1; pcnext = 32'h0000_0106;
    cyc();
    idle_in(); pcsrc = 1'b1; pcnext = 32'hFFFF_FFFC;
    #1;
    chk("t5_align", PCF, 32'h0000_0104);
    cyc();
    idle_in(); gnt = 1'b1;
    #1;
    chk("t5_PCF_top", PCF, 32'hFFFF_FFFC);
    cyc();
    idle_in(); rvalid = 1'b1; rdata = 32'h0AAA_0AAA; pcnext = 32'h0;
    cyc();
    idle_in();
    #1;
    chk("t5_wrap", PCPlus4D, 32'h0);
    chk("t5_PCD", PCD, 32'hFFFF_FFFC);
    chk("t5_InstrD", InstrD, 32'h0AAA_0AAA);
    chk("t5_PCF", PCF, 32'h0);

    // reset mid-WAIT, stray response afterwards
    pcsrc = 1'b1; pcnext = 32'h300;
    cyc();
    idle_in(); gnt = 1'b1;
    cyc();
    idle_in(); rst = 1'b1;
    #1;
    chk("t6_rst_noreq", {31'b0, imem_req}, 32'h0);
    cyc();
    idle_in(); rvalid = 1'b1; rdata = 32'hBADB_ADBA;
    #1;
    chk("t6_PCF", PCF, 32'h0);
    chk("t6_validD", {31'b0, validD}, 32'h0);
    cyc();
    idle_in();
    #1;
    chk("t6_InstrD", InstrD, NOP);
    chk("t6_validD2", {31'b0, validD}, 32'h0);
    chk("t6_PCF2", PCF, 32'h0);

    // randomized run; memory withholds grants while it still owes a response
    mem_cnt = 0;
    hs = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      cyc();
      if (hs) mem_cnt = $urandom_range(1, 3);
      rvalid = 1'b0;
      if (mem_cnt > 0) begin
        if (mem_cnt == 1) rvalid = 1'b1;
        mem_cnt--;
      end else if ($urandom_range(0, 7) == 0) begin
        rvalid = 1'b1;
      end
      rdata = $urandom;
      rst   = ($urandom_range(0, 63) == 0);
      pcsrc = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      r = $urandom;
      pcnext = ($urandom_range(0, 15) == 0) ? {30'h3FFF_FFFF, r[1:0]} : r;
      gnt = (mem_cnt == 0) && ($urandom_range(0, 3) != 0);
      #1;
      hs = imem_req && gnt;
    end
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The parameter DPW SHALL default to rv32i_pkg::DPW (32) and set the datapath/address width.
REQ-002 The parameter RESET_PC SHALL default to 32'h0000_0000 and set the first fetch address.
REQ-003 The parameter NOP_INSTR SHALL default to 32'h0000_0013 (addi x0,x0,0) and is the bubble instruction.
REQ-004 The port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The port rst SHALL be an input, 1 bit: reset, synchronous and active-high.
REQ-006 The port PCNext SHALL be an input, DPW bits: next PC from the branch unit (PCPlus4 or PCTarget).
REQ-007 The port PCSrcE SHALL be an input, 1 bit: taken-branch redirect from EX.
REQ-008 The port stallF SHALL be an input, 1 bit: hazard-unit stall of the F and D stages.
REQ-009 The port imem_req SHALL be an output, 1 bit: instruction memory request.
REQ-010 The port imem_addr SHALL be an output, DPW bits: request address; always equals PCF.
REQ-011 The port imem_gnt SHALL be an input, 1 bit: request accepted in the same cycle.
REQ-012 The port imem_rvalid SHALL be an input, 1 bit: read data valid, at least 1 cycle after the grant.
REQ-013 The port imem_rdata SHALL be an input, 32 bits: instruction word.
REQ-014 The port PCF SHALL be an output, DPW bits: current fetch PC, which feeds the branch unit.
REQ-015 The ports InstrD, PCD and PCPlus4D SHALL be outputs of 32, DPW and DPW bits: the IF/ID register.
REQ-016 The port validD SHALL be an output, 1 bit: InstrD holds a real instruction.

Function
REQ-017 The block SHALL implement an FSM with states FETCH, WAIT, HOLD and DRAIN, with at most one memory request outstanding.
REQ-018 imem_req SHALL be the combinational term (state==FETCH) & ~PCSrcE & ~stallF.
REQ-019 FETCH SHALL behave as follows:
- If imem_req & imem_gnt, go to WAIT.
- Otherwise remain in FETCH.
REQ-020 WAIT, with PCSrcE high, SHALL behave as follows:
- If imem_rvalid is also high, discard the data and go to FETCH.
- Otherwise go to DRAIN.
REQ-021 WAIT, with imem_rvalid high and PCSrcE low, SHALL behave as follows:
- If stallF is low, perform an accept (REQ-024) and go to FETCH.
- If stallF is high, store imem_rdata in a hold register and go to HOLD.
REQ-022 HOLD SHALL behave as follows:
- If PCSrcE is high, drop the held word and go to FETCH.
- Else if stallF is low, accept the held word and go to FETCH.
- Otherwise remain in HOLD.
REQ-023 DRAIN SHALL discard the response on imem_rvalid and go to FETCH; the IF/ID register is not written in DRAIN.
REQ-024 An accept SHALL perform all of the following on the same edge:
- InstrD <= word.
- PCD <= PCF.
- PCPlus4D <= PCF + 4 (modulo 2^DPW).
- validD <= 1.
- PCF <= PCNext.
REQ-025 When PCSrcE is high in any state, the block SHALL perform all of the following:
- PCF <= PCNext.
- InstrD <= NOP_INSTR.
- validD <= 0.
REQ-026 PCF SHALL always be word aligned: every load writes {PCNext[DPW-1:2], 2'b00}.
REQ-027 When stallF is high and PCSrcE is low, PCF and the IF/ID register SHALL hold their values.
REQ-028 When there is no stall, no accept and no PCSrcE, the block SHALL insert a bubble: InstrD <= NOP_INSTR and validD <= 0, with PCD and PCPlus4D unchanged.
REQ-029 Priority SHALL be rst > PCSrcE > stallF > accept.
REQ-030 PCF + 4 wrapping from 32'hFFFF_FFFC SHALL give 32'h0000_0000 with no error indication.
REQ-031 imem_rvalid arriving outside WAIT or DRAIN SHALL be ignored.
REQ-032 Throughput SHALL be one instruction per 2 cycles with a 1-cycle memory and no stalls; no prefetch is performed.

Reset
REQ-033 On rst the block SHALL set all of the following on the next edge:
- state = FETCH.
- PCF = RESET_PC.
- InstrD = NOP_INSTR.
- PCD = 0, PCPlus4D = 0, validD = 0.
- The hold register is cleared.
REQ-034 imem_req SHALL be low in every cycle in which rst is high.
REQ-035 A reset while in WAIT or DRAIN SHALL abandon the outstanding response; a late imem_rvalid in FETCH is ignored per REQ-031.

Verification
REQ-036 Reset then fetch: rst 1 cycle, gnt immediately, rvalid 1 cycle later with rdata=32'h0050_0093, PCNext=4 -> InstrD=32'h0050_0093, PCD=0, PCPlus4D=4, validD=1, PCF=4.
REQ-037 Redirect during WAIT: PCSrcE=1 with PCNext=32'h100 while rvalid is pending -> PCF=32'h100, validD=0, state DRAIN; the next rvalid is dropped and the next imem_addr is 32'h100.
REQ-038 Stall on response: stallF=1 when rvalid arrives with rdata=32'hDEAD_BEEF -> state HOLD, IF/ID unchanged; stallF released 3 cycles later -> InstrD=32'hDEAD_BEEF, validD=1.
REQ-039 Simultaneous events: PCSrcE=1, stallF=1 and rvalid=1 in the same WAIT cycle -> redirect wins, PCF=PCNext, validD=0, state FETCH.
REQ-040 Alignment and wrap: PCNext=32'h0000_0106 -> PCF=32'h0000_0104; PCF=32'hFFFF_FFFC accepted -> PCPlus4D=32'h0000_0000.
REQ-041 Reset mid-WAIT: assert rst in WAIT, then drive a stray rvalid after release -> PCF=RESET_PC, validD=0, stray data never reaches InstrD.
